// File: rtl/cache_refill_ctrl.sv
// Miss/refill and writeback controller between a 4-way set-associative cache
// and backing memory.
//
// A held miss level becomes one line read on a valid/ready memory port.
// The returned line comes back to the cache with a one-cycle response pulse.
// The victim line evicted on that refill is parked in a 1-entry writeback
// buffer and written to memory before any further read is issued.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_cache_miss        miss level, held until the response is taken
//   i_tag, i_index      address of the missing access
//   i_evict             victim flag, sampled the cycle after the response
//   i_evict_addr/data   victim line address and data
//   o_memory_line       refill line, valid while o_memory_response is high
//   o_memory_response   one-cycle refill pulse
//   o_mem_req/we/addr/wdata  registered memory request (we=1 writeback)
//   i_mem_ready         request accepted when o_mem_req && i_mem_ready
//   i_mem_rvalid/rdata  read data return
//   o_busy              high whenever the controller is not idle
//   o_timeout           sticky read-timeout flag, cleared only by rst
module cache_refill_ctrl #(
  parameter int unsigned TAG_BITS        = 18,
  parameter int unsigned INDEX_BITS      = 8,
  parameter int unsigned OFFSET_BITS     = 6,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned LINE_SIZE_BYTES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_cache_miss,
  input  logic [TAG_BITS-1:0]            i_tag,
  input  logic [INDEX_BITS-1:0]          i_index,
  input  logic                           i_evict,
  input  logic [ADDRESS_WIDTH-1:0]       i_evict_addr,
  input  logic [8*LINE_SIZE_BYTES-1:0]   i_evict_data,
  output logic [8*LINE_SIZE_BYTES-1:0]   o_memory_line,
  output logic                           o_memory_response,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]       o_mem_addr,
  output logic [8*LINE_SIZE_BYTES-1:0]   o_mem_wdata,
  input  logic                           i_mem_ready,
  input  logic                           i_mem_rvalid,
  input  logic [8*LINE_SIZE_BYTES-1:0]   i_mem_rdata,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int unsigned LINE_BITS = 8 * LINE_SIZE_BYTES;
  localparam int unsigned CNT_BITS  = $clog2(TIMEOUT_CYCLES);

  // Clears the offset field of a victim address to make it line aligned.
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    ~ADDRESS_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB_REQ  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;
  localparam logic [2:0] S_EVCAP   = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [ADDRESS_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [LINE_BITS-1:0]     wb_data_q, wb_data_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;

  logic [LINE_BITS-1:0]     line_d;
  logic                     resp_d;
  logic                     req_d;
  logic                     we_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [LINE_BITS-1:0]     wdata_d;
  logic                     busy_d;
  logic                     tmo_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    cnt_d       = cnt_q;
    line_d      = o_memory_line;
    tmo_d       = o_timeout;
    resp_d      = 1'b0;
    req_d       = 1'b0;
    we_d        = 1'b0;
    busy_d      = 1'b0;
    addr_d      = o_mem_addr;
    wdata_d     = o_mem_wdata;

    case (state_q)
      S_IDLE: begin
        // A parked victim must reach memory before the next read goes out.
        if (wb_valid_q) begin
          state_d = S_WB_REQ;
        end else if (i_cache_miss) begin
          state_d     = S_RD_REQ;
          miss_addr_d = ADDRESS_WIDTH'({i_tag, i_index, {OFFSET_BITS{1'b0}}});
        end
      end
      S_WB_REQ: begin
        if (i_mem_ready) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (i_mem_ready) begin
          cnt_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // Returned data wins over a timeout in the same cycle.
        if (i_mem_rvalid) begin
          line_d  = i_mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_RD_REQ;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      S_RESP: begin
        state_d = S_EVCAP;
      end
      S_EVCAP: begin
        // The miss level is still dropping here, so only the victim is looked at.
        if (i_evict) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = i_evict_addr & LINE_MASK;
          wb_data_d  = i_evict_data;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    resp_d = (state_d == S_RESP);
    busy_d = (state_d != S_IDLE);
    req_d  = (state_d == S_WB_REQ) || (state_d == S_RD_REQ);
    we_d   = (state_d == S_WB_REQ);
    if (state_d == S_WB_REQ) begin
      addr_d  = wb_addr_d;
      wdata_d = wb_data_d;
    end else if (state_d == S_RD_REQ) begin
      addr_d = miss_addr_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_addr_q       <= '0;
      wb_valid_q        <= 1'b0;
      wb_addr_q         <= '0;
      wb_data_q         <= '0;
      cnt_q             <= '0;
      o_memory_line     <= '0;
      o_memory_response <= 1'b0;
      o_mem_req         <= 1'b0;
      o_mem_we          <= 1'b0;
      o_mem_addr        <= '0;
      o_mem_wdata       <= '0;
      o_busy            <= 1'b0;
      o_timeout         <= 1'b0;
    end else begin
      miss_addr_q       <= miss_addr_d;
      wb_valid_q        <= wb_valid_d;
      wb_addr_q         <= wb_addr_d;
      wb_data_q         <= wb_data_d;
      cnt_q             <= cnt_d;
      o_memory_line     <= line_d;
      o_memory_response <= resp_d;
      o_mem_req         <= req_d;
      o_mem_we          <= we_d;
      o_mem_addr        <= addr_d;
      o_mem_wdata       <= wdata_d;
      o_busy            <= busy_d;
      o_timeout         <= tmo_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: a cycle table for one full
// refill + writeback, directed multi-cycle corner cases, and a randomized
// run against a transaction-level model of the cache and memory sides.
module tb_cache_refill_ctrl;

  localparam int unsigned TO    = 4;
  localparam int unsigned NRAND = 30;

  logic        clk;
  logic        rst;
  logic        i_cache_miss;
  logic [17:0] i_tag;
  logic [7:0]  i_index;
  logic        i_evict;
  logic [31:0] i_evict_addr;
  logic [31:0] i_evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_timeout;

  cache_refill_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_cache_miss(i_cache_miss), .i_tag(i_tag), .i_index(i_index),
    .i_evict(i_evict), .i_evict_addr(i_evict_addr), .i_evict_data(i_evict_data),
    .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  typedef struct {
    logic        miss;
    logic [17:0] tag;
    logic [7:0]  idx;
    logic        evict;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] line;
    logic        resp;
    logic        busy;
    logic        tmo;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] line_addr(input logic [17:0] t, input logic [7:0] i);
    return (32'(t) << 14) | (32'(i) << 6);
  endfunction

  function automatic logic [100:0] outs();
    return {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_memory_line,
            o_memory_response, o_busy, o_timeout};
  endfunction

  task automatic idle_inputs();
    i_cache_miss = 1'b0; i_tag = '0; i_index = '0;
    i_evict = 1'b0; i_evict_addr = '0; i_evict_data = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Random-run model state
  logic [63:0] wb_q[$];
  logic [31:0] exp_raddr, exp_line;
  logic [31:0] pre_addr, pre_wdata;
  logic        pre_req, pre_we, pre_ready;
  logic        miss_on, awaiting, rd_out, exp_resp, exp_tmo, tmo_due, ev_now;
  int          ev_wait, gap, rd_k, rd_d, issued, done, acc, rc;
  logic [31:0] a_tmp;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("reset_outputs", 128'(outs()), 128'(0));
    rst = 1'b0;

    // miss tag=5 index=3, data two cycles after accept, victim parked and drained
    a_tmp = line_addr(18'd5, 8'd3);
    vecs[0] = '{1'b1, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, a_tmp, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, a_tmp, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, a_tmp, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF,
                1'b0, 1'b0, a_tmp, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, a_tmp, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 18'd5, 8'd3, 1'b1, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, a_tmp, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b1, 32'h12345640, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b1, 32'h12345640, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h12345640, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 18'd5, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h11111111,
                1'b0, 1'b0, 32'h12345640, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};

    for (int v = 0; v < NV; v++) begin
      i_cache_miss = vecs[v].miss;  i_tag = vecs[v].tag; i_index = vecs[v].idx;
      i_evict = vecs[v].evict; i_evict_addr = vecs[v].eaddr; i_evict_data = vecs[v].edata;
      i_mem_ready = vecs[v].ready; i_mem_rvalid = vecs[v].rvalid; i_mem_rdata = vecs[v].rdata;
      step();
      chk($sformatf("vec%0d", v), 128'(outs()),
          128'({vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].line,
                vecs[v].resp, vecs[v].busy, vecs[v].tmo}));
    end

    // ready held low five cycles: request must hold, then one accept
    do_reset();
    acc = 0;
    i_cache_miss = 1'b1; i_tag = 18'h2ABCD; i_index = 8'h5A; i_mem_ready = 1'b0;
    step();
    a_tmp = line_addr(18'h2ABCD, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", 128'({o_mem_req, o_mem_we, o_mem_addr}), 128'({1'b1, 1'b0, a_tmp}));
      if (o_mem_req && i_mem_ready) acc++;
      step();
    end
    i_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (o_mem_req && i_mem_ready) acc++;
      i_mem_rvalid = (i == 1);
      i_mem_rdata  = 32'h0BADF00D;
      if (i >= 2) i_cache_miss = 1'b0;
      step();
      if (i == 1) chk("stall_resp", 128'({o_memory_response, o_memory_line}), 128'({1'b1, 32'h0BADF00D}));
    end
    i_mem_rvalid = 1'b0;
    step();
    chk("single_accept", 128'(acc), 128'(1));
    chk("stall_idle", 128'({o_busy, o_mem_req}), 128'(0));

    // no data for TO cycles: sticky timeout and same-address reissue
    do_reset();
    i_cache_miss = 1'b1; i_tag = 18'h3FFFF; i_index = 8'hFF; i_mem_ready = 1'b1;
    step();
    step();
    i_mem_ready = 1'b0;
    for (int k = 1; k < TO; k++) begin
      step();
      chk("tmo_wait", 128'({o_mem_req, o_timeout, o_busy}), 128'(3'b001));
    end
    step();
    chk("tmo_reissue", 128'({o_mem_req, o_mem_we, o_mem_addr, o_timeout}),
        128'({1'b1, 1'b0, 32'hFFFFFFC0, 1'b1}));
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    chk("tmo_reaccept", 128'({o_mem_req, o_timeout}), 128'(2'b01));
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h600DCAFE;
    step();
    chk("tmo_resp", 128'({o_memory_response, o_memory_line}), 128'({1'b1, 32'h600DCAFE}));
    i_mem_rvalid = 1'b0; i_cache_miss = 1'b0;
    step();
    step();
    chk("tmo_sticky", 128'({o_timeout, o_busy}), 128'(2'b10));

    // writeback pending and a new miss together in IDLE
    do_reset();
    i_cache_miss = 1'b1; i_tag = 18'd1; i_index = 8'd1; i_mem_ready = 1'b1;
    step();
    step();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hA5A5A5A5;
    step();
    chk("wbm_resp1", 128'(o_memory_response), 128'(1));
    i_mem_rvalid = 1'b0; i_cache_miss = 1'b0;
    step();
    i_evict = 1'b1; i_evict_addr = 32'hFFFFFFFF; i_evict_data = 32'h5A5A5A5A;
    i_cache_miss = 1'b1; i_tag = 18'd2; i_index = 8'd2; i_mem_ready = 1'b0;
    step();
    chk("wbm_evcap_ignores_miss", 128'({o_mem_req, o_busy}), 128'(0));
    i_evict = 1'b0;
    step();
    chk("wbm_write_first", 128'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}),
        128'({1'b1, 1'b1, 32'hFFFFFFC0, 32'h5A5A5A5A}));
    i_mem_ready = 1'b1;
    step();
    chk("wbm_write_done", 128'({o_mem_req, o_busy}), 128'(0));
    step();
    chk("wbm_read_next", 128'({o_mem_req, o_mem_we, o_mem_addr}),
        128'({1'b1, 1'b0, line_addr(18'd2, 8'd2)}));
    rc = 0;
    for (int i = 0; i < 5; i++) begin
      i_mem_rvalid = (i == 1);
      i_mem_rdata  = 32'h77778888;
      if (i >= 2) i_cache_miss = 1'b0;
      step();
      if (o_memory_response) rc++;
    end
    chk("wbm_one_resp", 128'(rc), 128'(1));

    // reset while waiting for read data; late rvalid must be ignored
    do_reset();
    i_cache_miss = 1'b1; i_tag = 18'd7; i_index = 8'd9; i_mem_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    #2;
    chk("async_reset", 128'(outs()), 128'(0));
    rst = 1'b0;
    i_cache_miss = 1'b0; i_mem_ready = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAADBAAD;
    step();
    chk("late_rvalid", 128'(outs()), 128'(0));
    i_mem_rvalid = 1'b0;
    step();
    chk("post_reset_idle", 128'(outs()), 128'(0));

    // randomized traffic against the transaction-level model
    do_reset();
    wb_q.delete();
    miss_on = 0; awaiting = 0; rd_out = 0; exp_tmo = 0; exp_resp = 0;
    ev_wait = 0; gap = 0; rd_k = 0; rd_d = 1; issued = 0; done = 0;
    exp_raddr = '0; exp_line = '0;
    for (int c = 0; c < 4000; c++) begin
      if (done >= NRAND && !miss_on && ev_wait == 0 && wb_q.size() == 0) break;
      ev_now = (ev_wait == 1);
      if (ev_wait > 0) ev_wait--;
      if (!miss_on && ev_wait == 0 && issued < NRAND) begin
        if (gap > 0) gap--;
        else begin
          miss_on = 1'b1;
          i_tag = 18'($urandom);
          i_index = 8'($urandom);
          exp_raddr = line_addr(i_tag, i_index);
          awaiting = 1'b1;
          issued++;
          gap = $urandom_range(0, 3);
        end
      end
      i_cache_miss = miss_on;
      i_evict = 1'b0;
      if (ev_now) begin
        i_evict = 1'($urandom_range(0, 1));
        i_evict_addr = $urandom;
        i_evict_data = $urandom;
        if (i_evict) wb_q.push_back({i_evict_addr & 32'hFFFFFFC0, i_evict_data});
      end
      i_mem_ready = ($urandom_range(0, 2) != 0);
      i_mem_rvalid = 1'b0;
      exp_resp = 1'b0;
      tmo_due = 1'b0;
      if (rd_out) begin
        rd_k++;
        if (rd_k == rd_d) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata = $urandom;
          exp_resp = 1'b1;
          exp_line = i_mem_rdata;
          rd_out = 1'b0;
        end else if (rd_k == TO) begin
          tmo_due = 1'b1;
          rd_out = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata = $urandom;
      end
      pre_req = o_mem_req; pre_we = o_mem_we; pre_addr = o_mem_addr;
      pre_wdata = o_mem_wdata; pre_ready = i_mem_ready;
      step();
      if (pre_req && pre_ready) begin
        if (wb_q.size() != 0) begin
          chk("rand_wb_accept", 128'({pre_we, pre_addr, pre_wdata}), 128'({1'b1, wb_q[0]}));
          void'(wb_q.pop_front());
        end else begin
          chk("rand_rd_accept", 128'({awaiting, pre_we, pre_addr}), 128'({1'b1, 1'b0, exp_raddr}));
          awaiting = 1'b0;
          rd_out = 1'b1;
          rd_k = 0;
          rd_d = $urandom_range(1, TO + 2);
        end
      end else if (pre_req) begin
        chk("rand_req_stable", 128'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}),
            128'({1'b1, pre_we, pre_addr, pre_wdata}));
      end
      chk("rand_resp", 128'(o_memory_response), 128'(exp_resp));
      if (exp_resp) begin
        chk("rand_line", 128'(o_memory_line), 128'(exp_line));
        miss_on = 1'b0;
        ev_wait = 2;
        done++;
      end
      if (tmo_due) begin
        exp_tmo = 1'b1;
        chk("rand_tmo_reissue", 128'({o_mem_req, o_mem_we, o_mem_addr, o_timeout}),
            128'({1'b1, 1'b0, exp_raddr, 1'b1}));
        awaiting = 1'b1;
      end else begin
        chk("rand_timeout_flag", 128'(o_timeout), 128'(exp_tmo));
      end
    end
    chk("rand_done", 128'(done), 128'(NRAND));
    chk("rand_wb_drained", 128'(wb_q.size()), 128'(0));
    chk("rand_idle", 128'({o_busy, o_mem_req}), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
